// File: rtl/sata_oob_device_pkg.sv
// Shared types and timing defaults for the device-side SATA OOB responder.
package sata_oob_device_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WAIT_RST  = 4'd1,
        S_RST_END   = 4'd2,
        S_COMINIT   = 4'd3,
        S_WAIT_WAKE = 4'd4,
        S_WAKE_END  = 4'd5,
        S_COMWAKE   = 4'd6,
        S_WAIT_DATA = 4'd7,
        S_ALIGN     = 4'd8,
        S_BACKOFF   = 4'd9,
        S_LINKUP    = 4'd10
    } oob_state_t;

    localparam int QUIET_CYCLES_DEF  = 64;
    localparam int ALIGN_TIMEOUT_DEF = 1600000;
    localparam int RETRY_CYCLES_DEF  = 8192;
    localparam int LW_DEF            = 21;

    // A host COMRESET seen in any of these states restarts the handshake.
    function automatic logic past_rst_end(input oob_state_t s);
        return s inside {S_COMINIT, S_WAIT_WAKE, S_WAKE_END, S_COMWAKE,
                         S_WAIT_DATA, S_ALIGN, S_BACKOFF, S_LINKUP};
    endfunction

    function automatic logic tx_active(input oob_state_t s);
        return (s == S_ALIGN) || (s == S_LINKUP);
    endfunction

endpackage

// File: rtl/sata_oob_device_if.sv
// OOB signal bundle between the GTX/PHY side (master) and the OOB responder (slave).
interface sata_oob_device_if;

    logic i_phy_ready;
    logic i_rx_comreset;
    logic i_rx_comwake;
    logic i_rx_elecidle;
    logic i_rx_align;
    logic i_tx_comfinish;
    logic o_tx_cominit;
    logic o_tx_comwake;
    logic o_tx_elecidle;
    logic o_tx_align;
    logic o_link_up;
    logic o_err;

    modport master (
        output i_phy_ready, i_rx_comreset, i_rx_comwake, i_rx_elecidle,
               i_rx_align, i_tx_comfinish,
        input  o_tx_cominit, o_tx_comwake, o_tx_elecidle, o_tx_align,
               o_link_up, o_err
    );

    modport slave (
        input  i_phy_ready, i_rx_comreset, i_rx_comwake, i_rx_elecidle,
               i_rx_align, i_tx_comfinish,
        output o_tx_cominit, o_tx_comwake, o_tx_elecidle, o_tx_align,
               o_link_up, o_err
    );

endinterface

// File: rtl/sata_oob_device_sync2.sv
// Two-flop synchronizer for the asynchronous rx electrical-idle indication.
module sata_oob_device_sync2 (
    input  logic i_clk,
    input  logic i_reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Resets to 1 so the line reads as idle until real samples arrive.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sata_oob_device.sv
// Device-side SATA OOB responder: answers host COMRESET with COMINIT,
// exchanges COMWAKE, then sends ALIGN until the host echoes it.
module sata_oob_device
    import sata_oob_device_pkg::*;
#(
    parameter int QUIET_CYCLES  = QUIET_CYCLES_DEF,
    parameter int ALIGN_TIMEOUT = ALIGN_TIMEOUT_DEF,
    parameter int RETRY_CYCLES  = RETRY_CYCLES_DEF,
    parameter int LW            = LW_DEF
) (
    input logic              i_clk,
    input logic              i_reset,
    sata_oob_device_if.slave bus
);

    localparam logic [LW-1:0] QUIET_LAST = LW'(QUIET_CYCLES - 1);
    localparam logic [LW-1:0] ALIGN_LAST = LW'(ALIGN_TIMEOUT - 1);
    localparam logic [LW-1:0] RETRY_LAST = LW'(RETRY_CYCLES - 1);

    oob_state_t    state, next_state;
    logic [LW-1:0] count, next_count;
    logic          rx_idle;
    logic          err_next;
    logic          tx_cominit_q, tx_comwake_q, tx_elecidle_q;
    logic          tx_align_q, link_up_q, err_q;

    sata_oob_device_sync2 u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .d       (bus.i_rx_elecidle),
        .q       (rx_idle)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            state <= next_state;
            count <= next_count;
        end
    end

    // Counter saturates; quiet states count consecutive idle cycles only.
    always_comb begin
        next_state = state;
        next_count = (&count) ? count : count + 1'b1;
        err_next   = 1'b0;
        case (state)
            S_IDLE:      if (bus.i_phy_ready)    next_state = S_WAIT_RST;
            S_WAIT_RST:  if (bus.i_rx_comreset)  next_state = S_RST_END;
            S_RST_END: begin
                if (!rx_idle)                    next_count = '0;
                else if (count == QUIET_LAST)    next_state = S_COMINIT;
            end
            S_COMINIT:   if (bus.i_tx_comfinish) next_state = S_WAIT_WAKE;
            S_WAIT_WAKE: if (bus.i_rx_comwake)   next_state = S_WAKE_END;
            S_WAKE_END: begin
                if (!rx_idle)                    next_count = '0;
                else if (count == QUIET_LAST)    next_state = S_COMWAKE;
            end
            S_COMWAKE:   if (bus.i_tx_comfinish) next_state = S_WAIT_DATA;
            S_WAIT_DATA: if (!rx_idle)           next_state = S_ALIGN;
            S_ALIGN: begin
                if (bus.i_rx_align) begin
                    next_state = S_LINKUP;
                end else if (count == ALIGN_LAST) begin
                    next_state = S_BACKOFF;
                    err_next   = 1'b1;
                end
            end
            S_BACKOFF:   if (count == RETRY_LAST) next_state = S_WAIT_RST;
            S_LINKUP:    next_state = S_LINKUP;
            default:     next_state = S_IDLE;
        endcase

        if (bus.i_rx_comreset && past_rst_end(state)) begin
            next_state = S_RST_END;
            next_count = '0;
            err_next   = 1'b0;
        end
        if (!bus.i_phy_ready) begin
            next_state = S_IDLE;
            next_count = '0;
            err_next   = 1'b0;
        end
        if (next_state != state) next_count = '0;
    end

    // Outputs follow the next state so requests pulse on the first cycle in state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tx_cominit_q  <= 1'b0;
            tx_comwake_q  <= 1'b0;
            tx_elecidle_q <= 1'b1;
            tx_align_q    <= 1'b0;
            link_up_q     <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            tx_cominit_q  <= (next_state == S_COMINIT) && (state != S_COMINIT);
            tx_comwake_q  <= (next_state == S_COMWAKE) && (state != S_COMWAKE);
            tx_elecidle_q <= !tx_active(next_state);
            tx_align_q    <= tx_active(next_state);
            link_up_q     <= (next_state == S_LINKUP);
            err_q         <= err_next;
        end
    end

    assign bus.o_tx_cominit  = tx_cominit_q;
    assign bus.o_tx_comwake  = tx_comwake_q;
    assign bus.o_tx_elecidle = tx_elecidle_q;
    assign bus.o_tx_align    = tx_align_q;
    assign bus.o_link_up     = link_up_q;
    assign bus.o_err         = err_q;

endmodule
